// File: rtl/aes_decipher_round_pkg.sv
// Shared constants, FSM encoding and the byte-permutation helper for the AES inverse-round engine.
// Latency: n/a (declarations and a combinational function only).
// Backpressure: n/a.
package aes_decipher_round_pkg;

    localparam logic [1:0] AES_ROUND_INIT  = 2'd0;
    localparam logic [1:0] AES_ROUND_MAIN  = 2'd1;
    localparam logic [1:0] AES_ROUND_FINAL = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SUB  = 1'b1
    } round_state_e;

    // Column c is word c (word0 = [127:96]) and row r is byte r of that word.
    // Row r rotates right by r, so output byte (r,c) comes from input byte (r,(c-r) mod 4).
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c - r + 4) % 4) - 8*r -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_decipher_round_if.sv
// Request/response bundle between the round controller and the inverse-round engine.
// Latency: n/a (wiring only).
// Backpressure: none on the wires; the engine's ready gates acceptance of next.
interface aes_decipher_round_if;
    logic         next;
    logic [1:0]   round_type;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic [127:0] new_block;
    logic         ready;

    // Controller side: issues rounds and owns the shared inverse S-box.
    modport master (
        output next, round_type, round_key, block, new_sboxw,
        input  sboxw, new_block, ready
    );

    // Engine side.
    modport slave (
        input  next, round_type, round_key, block, new_sboxw,
        output sboxw, new_block, ready
    );
endinterface

// File: rtl/aes_decipher_round_inv_mixw.sv
// InvMixColumns of one 32-bit column, byte0 in [31:24].
// Latency: combinational.
// Backpressure: none.
module aes_inv_mixw (
    input  logic [31:0] w,
    output logic [31:0] m
);

    function automatic logic [7:0] gm02(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm04(input logic [7:0] a);
        return gm02(gm02(a));
    endfunction

    function automatic logic [7:0] gm08(input logic [7:0] a);
        return gm02(gm04(a));
    endfunction

    function automatic logic [7:0] gm09(input logic [7:0] a);
        return gm08(a) ^ a;
    endfunction

    function automatic logic [7:0] gm0b(input logic [7:0] a);
        return gm08(a) ^ gm02(a) ^ a;
    endfunction

    function automatic logic [7:0] gm0d(input logic [7:0] a);
        return gm08(a) ^ gm04(a) ^ a;
    endfunction

    function automatic logic [7:0] gm0e(input logic [7:0] a);
        return gm08(a) ^ gm04(a) ^ gm02(a);
    endfunction

    logic [7:0] b0, b1, b2, b3;

    assign b0 = w[31:24];
    assign b1 = w[23:16];
    assign b2 = w[15:8];
    assign b3 = w[7:0];

    // Each output row is the {0e,0b,0d,09} row rotated right by the row index.
    always_comb begin
        m[31:24] = gm0e(b0) ^ gm0b(b1) ^ gm0d(b2) ^ gm09(b3);
        m[23:16] = gm09(b0) ^ gm0e(b1) ^ gm0b(b2) ^ gm0d(b3);
        m[15:8]  = gm0d(b0) ^ gm09(b1) ^ gm0e(b2) ^ gm0b(b3);
        m[7:0]   = gm0b(b0) ^ gm0d(b1) ^ gm09(b2) ^ gm0e(b3);
    end

endmodule

// File: rtl/aes_decipher_round.sv
// Iterative AES inverse round: key add / InvMixColumns / InvShiftRows in one edge, then InvSubBytes a word per edge.
// Latency: INIT/MAIN result valid 5 edges after acceptance, FINAL 1 edge; ready=0 while substituting.
// Backpressure: next is only sampled while ready=1; requests during a round are dropped, not queued.
module aes_decipher_round
    import aes_decipher_round_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    aes_decipher_round_if.slave bus
);

    round_state_e state_q, state_d;
    logic [1:0]   ctr_q, ctr_d;
    logic [127:0] blk_q, blk_d;

    logic [127:0] addkey;
    logic [127:0] imc;
    logic [31:0]  cur_word;

    assign addkey = bus.block ^ bus.round_key;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_imc
            aes_inv_mixw u_mixw (
                .w (addkey[127 - 32*g -: 32]),
                .m (imc[127 - 32*g -: 32])
            );
        end
    endgenerate

    // Word under substitution; in IDLE the counter rests at 0 so word0 is presented.
    always_comb begin
        cur_word = blk_q[127:96];
        case (ctr_q)
            2'd0: cur_word = blk_q[127:96];
            2'd1: cur_word = blk_q[95:64];
            2'd2: cur_word = blk_q[63:32];
            2'd3: cur_word = blk_q[31:0];
            default: cur_word = blk_q[127:96];
        endcase
    end

    assign bus.sboxw     = cur_word;
    assign bus.new_block = blk_q;
    assign bus.ready     = (state_q == ST_IDLE);

    // Round acceptance in IDLE and word-by-word S-box write-back in SUB.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        blk_d   = blk_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.next) begin
                    case (bus.round_type)
                        AES_ROUND_INIT: begin
                            blk_d   = inv_shift_rows(addkey);
                            ctr_d   = 2'd0;
                            state_d = ST_SUB;
                        end
                        AES_ROUND_MAIN: begin
                            blk_d   = inv_shift_rows(imc);
                            ctr_d   = 2'd0;
                            state_d = ST_SUB;
                        end
                        AES_ROUND_FINAL: begin
                            blk_d   = addkey;
                        end
                        default: begin
                            // Reserved round type: leave everything untouched.
                        end
                    endcase
                end
            end
            ST_SUB: begin
                case (ctr_q)
                    2'd0: blk_d[127:96] = bus.new_sboxw;
                    2'd1: blk_d[95:64]  = bus.new_sboxw;
                    2'd2: blk_d[63:32]  = bus.new_sboxw;
                    2'd3: blk_d[31:0]   = bus.new_sboxw;
                    default: blk_d = blk_q;
                endcase
                ctr_d = ctr_q + 2'd1;
                if (ctr_q == 2'd3) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and block registers; reset abandons any round in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ctr_q   <= 2'd0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            blk_q   <= blk_d;
        end
    end

endmodule

// File: tb/tb_aes_decipher_round.sv
// Scoreboard bench for the AES inverse-round engine using FIPS-197 inverse-cipher vectors.
// Latency: expectations are scheduled per cycle; the monitor compares at the falling edge.
// Backpressure: exercises next held high, next during a round, and the return-to-idle edge.
module tb_aes_decipher_round;
    import aes_decipher_round_pkg::*;

    logic clk;
    logic reset;
    int   cyc;
    int   n_tests;
    int   n_fail;

    aes_decipher_round_if bus_if ();

    aes_decipher_round dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External inverse S-box model: inverse affine map followed by GF(2^8) inversion (x^254).
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r, t, e;
        r = 8'h01; t = x; e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[0]) r = gmul(r, t);
            t = gmul(t, t);
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

    assign bus_if.new_sboxw = {inv_sbox(bus_if.sboxw[31:24]), inv_sbox(bus_if.sboxw[23:16]),
                               inv_sbox(bus_if.sboxw[15:8]),  inv_sbox(bus_if.sboxw[7:0])};

    // Directed vectors (FIPS-197 C.1 inverse cipher, rounds 1 and 2).
    localparam logic [127:0] B0    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K0    = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] S0    = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
    localparam logic [127:0] R0    = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] K1    = 128'h549932d1f08557681093ed9cbe2c974e;
    localparam logic [127:0] S1    = 128'h5411f4b56bd9700e96a0902fa1bb9aa1;
    localparam logic [127:0] R1    = 128'hfde3bad205e5d0d73547964ef1fe37f1;
    localparam logic [127:0] BF    = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] KF    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RF    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] JUNK  = 128'hdeadbeefcafef00d0123456789abcdef;

    typedef struct {
        int           due;
        string        name;
        logic [127:0] blk;
        bit           chk_blk;
        logic         rdy;
        logic [31:0]  sbw;
        bit           chk_sbw;
    } exp_t;

    exp_t sb[$];

    task automatic expect_at(input int due, input string nm, input logic [127:0] b, input bit cb,
                             input logic r, input logic [31:0] s, input bit cs);
        exp_t e;
        e.due = due; e.name = nm; e.blk = b; e.chk_blk = cb;
        e.rdy = r; e.sbw = s; e.chk_sbw = cs;
        sb.push_back(e);
    endtask

    // Expected trace of an INIT/MAIN round accepted at edge k: four busy cycles walking the
    // shifted state word by word through the S-box, then the finished block with ready high.
    task automatic expect_sub(input int k, input string nm, input logic [127:0] st, input logic [127:0] res);
        for (int j = 0; j < 4; j++) begin
            expect_at(k + j, $sformatf("%s_sub%0d", nm, j), st, (j == 0), 1'b0, st[127 - 32*j -: 32], 1'b1);
        end
        expect_at(k + 4, $sformatf("%s_done", nm), res, 1'b1, 1'b1, res[127:96], 1'b1);
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic drive(input logic nx, input logic [1:0] rt, input logic [127:0] b, input logic [127:0] k);
        bus_if.next       = nx;
        bus_if.round_type = rt;
        bus_if.block      = b;
        bus_if.round_key  = k;
    endtask

    // Monitor: pops every expectation that falls due this cycle and compares it with the outputs.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s missed: checked at cycle %0d, due at %0d", e.name, cyc, e.due);
            end else begin
                n_tests++;
                if (bus_if.ready !== e.rdy) begin
                    n_fail++;
                    $display("FAIL %s ready: got %0b want %0b", e.name, bus_if.ready, e.rdy);
                end
                if (e.chk_blk) begin
                    n_tests++;
                    if (bus_if.new_block !== e.blk) begin
                        n_fail++;
                        $display("FAIL %s new_block: got %h want %h", e.name, bus_if.new_block, e.blk);
                    end
                end
                if (e.chk_sbw) begin
                    n_tests++;
                    if (bus_if.sboxw !== e.sbw) begin
                        n_fail++;
                        $display("FAIL %s sboxw: got %h want %h", e.name, bus_if.sboxw, e.sbw);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        reset   = 1'b1;
        drive(1'b0, AES_ROUND_INIT, '0, '0);

        // Reset state.
        tick;
        expect_at(cyc + 1, "reset", '0, 1'b1, 1'b1, 32'h0, 1'b1);
        tick;
        reset = 1'b0;
        tick;

        // INIT round.
        drive(1'b1, AES_ROUND_INIT, B0, K0);
        k = cyc + 1;
        expect_sub(k, "init", S0, R0);
        tick;
        bus_if.next = 1'b0;
        repeat (5) tick;

        // MAIN round with next pulsed and inputs scrambled during SUB, next still high on the return edge.
        drive(1'b1, AES_ROUND_MAIN, R0, K1);
        k = cyc + 1;
        expect_sub(k, "main", S1, R1);
        expect_at(k + 5, "main_hold", R1, 1'b1, 1'b1, R1[127:96], 1'b1);
        tick;
        drive(1'b1, AES_ROUND_FINAL, JUNK, ~JUNK);
        repeat (3) tick;
        tick;
        drive(1'b0, AES_ROUND_MAIN, R0, K1);
        repeat (2) tick;

        // FINAL round: single edge, ready stays high.
        drive(1'b1, AES_ROUND_FINAL, BF, KF);
        expect_at(cyc + 1, "final", RF, 1'b1, 1'b1, RF[127:96], 1'b1);
        expect_at(cyc + 2, "final_hold", RF, 1'b1, 1'b1, RF[127:96], 1'b1);
        tick;
        bus_if.next = 1'b0;
        tick;

        // Reserved round type is ignored.
        drive(1'b1, 2'd3, JUNK, ~JUNK);
        expect_at(cyc + 1, "invalid", RF, 1'b1, 1'b1, RF[127:96], 1'b1);
        tick;
        bus_if.next = 1'b0;
        tick;

        // Reset during the second SUB cycle of an INIT round.
        drive(1'b1, AES_ROUND_INIT, B0, K0);
        k = cyc + 1;
        expect_at(k, "rst_sub0", S0, 1'b1, 1'b0, S0[127:96], 1'b1);
        tick;
        bus_if.next = 1'b0;
        expect_at(k + 1, "rst_sub1", S0, 1'b0, 1'b0, S0[95:64], 1'b1);
        tick;
        reset = 1'b1;
        expect_at(k + 2, "rst_abort", '0, 1'b1, 1'b1, 32'h0, 1'b1);
        tick;
        reset = 1'b0;
        drive(1'b1, AES_ROUND_INIT, B0, K0);
        k = cyc + 1;
        expect_sub(k, "reinit", S0, R0);
        tick;
        bus_if.next = 1'b0;
        repeat (5) tick;

        // Back-to-back: next held high from INIT into MAIN, inputs switched when ready rises.
        drive(1'b1, AES_ROUND_INIT, B0, K0);
        k = cyc + 1;
        expect_sub(k, "b2b_init", S0, R0);
        repeat (5) tick;
        drive(1'b1, AES_ROUND_MAIN, R0, K1);
        k = cyc + 1;
        expect_sub(k, "b2b_main", S1, R1);
        repeat (5) tick;
        bus_if.next = 1'b0;
        expect_at(cyc + 1, "b2b_idle", R1, 1'b1, 1'b1, R1[127:96], 1'b1);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            tick;
        end
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s never checked: due %0d, now %0d", e.name, e.due, cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
